// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with enable, clear, load, wrap/saturate mode,
// a registered terminal-count pulse and a sticky boundary-event flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned RST_VAL  = 0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up_dn,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] MaxC  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RstC  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] OneC  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZeroC = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_d;
    logic             w_tc_d;
    logic             w_ovf_d;
    logic             w_event;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max       = (r_count == MaxC);
    assign w_at_zero      = (r_count == ZeroC);
    assign w_load_clamped = (i_load_val > MaxC) ? MaxC : i_load_val;

    // Priority clr > load > en; only an enabled step at a boundary is an event.
    always_comb begin
        w_count_d = r_count;
        w_event   = 1'b0;
        if (i_clr) begin
            w_count_d = RstC;
        end else if (i_load) begin
            w_count_d = w_load_clamped;
        end else if (i_en) begin
            if (i_up_dn) begin
                if (w_at_max) begin
                    w_event   = 1'b1;
                    w_count_d = SATURATE ? MaxC : ZeroC;
                end else begin
                    w_count_d = r_count + OneC;
                end
            end else begin
                if (w_at_zero) begin
                    w_event   = 1'b1;
                    w_count_d = SATURATE ? ZeroC : MaxC;
                end else begin
                    w_count_d = r_count - OneC;
                end
            end
        end
    end

    assign w_tc_d = w_event;

    // Set wins over a same-edge clear.
    always_comb begin
        w_ovf_d = r_ovf;
        if (w_event) begin
            w_ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            w_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= RstC;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_tc    <= w_tc_d;
            r_ovf   <= w_ovf_d;
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a wrapping and a saturating instance (WIDTH=4,
// MAX_VAL=9), expected results queued at drive time and checked after each edge.
module tb_updown_mod_counter;

    typedef struct {
        int         sel;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapping instance inputs/outputs
    logic       w_rst = 1'b1, w_en = 1'b0, w_up = 1'b1, w_clr = 1'b0, w_load = 1'b0;
    logic       w_oc = 1'b0;
    logic [3:0] w_lv = 4'd0;
    logic [3:0] w_count;
    logic       w_tc, w_ovf;

    // Saturating instance inputs/outputs
    logic       s_rst = 1'b1, s_en = 1'b0, s_up = 1'b1, s_clr = 1'b0, s_load = 1'b0;
    logic       s_oc = 1'b0;
    logic [3:0] s_lv = 4'd0;
    logic [3:0] s_count;
    logic       s_tc, s_ovf;

    updown_mod_counter #(
        .WIDTH(4), .MAX_VAL(9), .RST_VAL(0), .SATURATE(1'b0)
    ) dut_wrap (
        .i_clk(clk), .i_rst(w_rst), .i_en(w_en), .i_up_dn(w_up), .i_clr(w_clr),
        .i_load(w_load), .i_load_val(w_lv), .i_ovf_clr(w_oc),
        .o_count(w_count), .o_tc(w_tc), .o_ovf(w_ovf)
    );

    updown_mod_counter #(
        .WIDTH(4), .MAX_VAL(9), .RST_VAL(0), .SATURATE(1'b1)
    ) dut_sat (
        .i_clk(clk), .i_rst(s_rst), .i_en(s_en), .i_up_dn(s_up), .i_clr(s_clr),
        .i_load(s_load), .i_load_val(s_lv), .i_ovf_clr(s_oc),
        .o_count(s_count), .o_tc(s_tc), .o_ovf(s_ovf)
    );

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check_front();
        exp_t       e;
        logic [3:0] c;
        logic       t, o;
        e = sb.pop_front();
        c = (e.sel == 0) ? w_count : s_count;
        t = (e.sel == 0) ? w_tc    : s_tc;
        o = (e.sel == 0) ? w_ovf   : s_ovf;
        n_assert++;
        assert (c === e.cnt) else begin
            n_fail++;
            $error("FAIL %s count: observed %0d expected %0d", e.tag, c, e.cnt);
        end
        n_assert++;
        assert (t === e.tc) else begin
            n_fail++;
            $error("FAIL %s tc: observed %0b expected %0b", e.tag, t, e.tc);
        end
        n_assert++;
        assert (o === e.ovf) else begin
            n_fail++;
            $error("FAIL %s ovf: observed %0b expected %0b", e.tag, o, e.ovf);
        end
    endtask

    // Drive one instance for one edge (the other idles), queue its expectation, check it.
    task automatic step(input int sel, input logic rst, input logic clr, input logic load,
                        input logic en, input logic up, input logic [3:0] lv, input logic oc,
                        input logic [3:0] ec, input logic et, input logic eo, input string tag);
        exp_t e;
        if (sel == 0) begin
            w_rst = rst; w_clr = clr; w_load = load; w_en = en; w_up = up; w_lv = lv;
            w_oc = oc;
            s_rst = 1'b0; s_clr = 1'b0; s_load = 1'b0; s_en = 1'b0; s_oc = 1'b0;
        end else begin
            s_rst = rst; s_clr = clr; s_load = load; s_en = en; s_up = up; s_lv = lv;
            s_oc = oc;
            w_rst = 1'b0; w_clr = 1'b0; w_load = 1'b0; w_en = 1'b0; w_oc = 1'b0;
        end
        e.sel = sel; e.cnt = ec; e.tc = et; e.ovf = eo; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        // Reset: two edges
        step(0, 1, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "rst0");
        step(0, 1, 0, 0, 1, 1, 4'd3, 0, 4'd0, 0, 0, "rst1");

        // Count up through the wrap
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, 0, 1, 1, 4'd0, 0, 4'(i), 0, 0, "up");
        end
        step(0, 0, 0, 0, 1, 1, 4'd0, 0, 4'd0, 1, 1, "up_wrap");
        step(0, 0, 0, 0, 1, 1, 4'd0, 0, 4'd1, 0, 1, "up_after_wrap");

        // Down from 2 through the wrap, then clear ovf
        step(0, 0, 0, 1, 1, 0, 4'd2, 0, 4'd2, 0, 1, "load2");
        step(0, 0, 0, 0, 1, 0, 4'd0, 0, 4'd1, 0, 1, "dn1");
        step(0, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 1, "dn0");
        step(0, 0, 0, 0, 1, 0, 4'd0, 0, 4'd9, 1, 1, "dn_wrap");
        step(0, 0, 0, 0, 1, 0, 4'd0, 0, 4'd8, 0, 1, "dn8");
        step(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd8, 0, 0, "ovf_clr");

        // Priority and load clamping
        step(0, 0, 1, 1, 1, 1, 4'd5, 0, 4'd0, 0, 0, "clr_over_load");
        step(0, 0, 0, 1, 0, 1, 4'd15, 0, 4'd9, 0, 0, "load_clamp");

        // Same-edge event and ovf_clr: set wins; then hold with en=0
        step(0, 0, 0, 0, 1, 1, 4'd0, 1, 4'd0, 1, 1, "evt_and_ovf_clr");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, "hold");
        end

        // Reset mid-count overrides load/en
        step(0, 0, 0, 1, 0, 1, 4'd5, 0, 4'd5, 0, 1, "load5");
        step(0, 0, 0, 0, 1, 1, 4'd0, 0, 4'd6, 0, 1, "up6");
        step(0, 1, 0, 1, 1, 1, 4'd3, 0, 4'd0, 0, 0, "rst_mid");

        // Saturating instance
        step(1, 1, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "s_rst");
        step(1, 0, 0, 1, 0, 1, 4'd8, 0, 4'd8, 0, 0, "s_load8");
        step(1, 0, 0, 0, 1, 1, 4'd0, 0, 4'd9, 0, 0, "s_up9");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1, 1, 4'd0, 0, 4'd9, 1, 1, "s_hold_max");
        end
        step(1, 0, 1, 0, 1, 1, 4'd0, 0, 4'd0, 0, 1, "s_clr");
        step(1, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 1, 1, "s_hold_zero");
        step(1, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 1, 1, "s_hold_zero2");
        step(1, 0, 0, 0, 0, 0, 4'd0, 1, 4'd0, 0, 0, "s_ovf_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
